// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage and the IF/ID interface.
//   if_state_t : fetch FSM states (FETCH issuing, HOLD skid full, DRAIN discarding)
//   NOP_INST   : instruction placed in IF/ID when it holds no live instruction
//   if_id_t    : one IF/ID register entry {pc, inst, valid}
package if_pkg;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } if_state_t;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  localparam int unsigned IF_PC_W = 64;

  typedef struct packed {
    logic [IF_PC_W-1:0] pc;
    logic [31:0]        inst;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetch that completes while ID is stalled.
//   clock, reset       : clock and synchronous active-high reset (empties the entry)
//   load               : capture load_pc/load_inst, entry becomes full
//   unload             : entry has been consumed, becomes empty
//   clear              : drop the entry (flush); wins over load and unload
//   full               : entry holds a live instruction
//   buf_pc, buf_inst   : stored entry
module if_skid_buffer #(
  parameter int unsigned DATA_SIZE = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 unload,
  input  logic                 clear,
  input  logic [DATA_SIZE-1:0] load_pc,
  input  logic [31:0]          load_inst,
  output logic                 full,
  output logic [DATA_SIZE-1:0] buf_pc,
  output logic [31:0]          buf_inst
);

  always_ff @(posedge clock) begin
    if (reset) begin
      full     <= 1'b0;
      buf_pc   <= '0;
      buf_inst <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full     <= 1'b1;
      buf_pc   <= load_pc;
      buf_inst <= load_inst;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage_issue.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory handshake and
// writes the IF/ID register. Honours ID stall and EX/MEM redirect.
//   clock, reset                  : clock and synchronous active-high reset
//   inst_mem_en/addr              : fetch request, held with stable address until ack
//   inst_mem_ack/rd_dat           : one-cycle completion pulse and fetched instruction
//   id_stall                      : ID cannot accept, IF/ID holds
//   redirect_en/redirect_pc       : flush and restart fetch at redirect_pc (word aligned)
//   if_id_valid/pc/inst           : IF/ID register (inst is NOP when invalid)
module if_stage_issue
  import if_pkg::*;
#(
  parameter int unsigned          DATA_SIZE = 64,
  parameter logic [DATA_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 inst_mem_en,
  output logic [DATA_SIZE-1:0] inst_mem_addr,
  input  logic                 inst_mem_ack,
  input  logic [31:0]          inst_mem_rd_dat,
  input  logic                 id_stall,
  input  logic                 redirect_en,
  input  logic [DATA_SIZE-1:0] redirect_pc,
  output logic                 if_id_valid,
  output logic [DATA_SIZE-1:0] if_id_pc,
  output logic [31:0]          if_id_inst
);

  if_state_t            state_q;
  logic [DATA_SIZE-1:0] pc_q;
  logic [DATA_SIZE-1:0] drain_addr_q;  // address of the transaction being drained

  logic                 skid_load, skid_unload, skid_full;
  logic [DATA_SIZE-1:0] skid_pc;
  logic [31:0]          skid_inst;
  logic [DATA_SIZE-1:0] redirect_target;

  assign redirect_target = redirect_pc & ~DATA_SIZE'(3);

  assign inst_mem_en   = !reset && (state_q != HOLD);
  assign inst_mem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

  assign skid_load   = (state_q == FETCH) && inst_mem_ack && id_stall && !redirect_en;
  assign skid_unload = (state_q == HOLD) && !id_stall && !redirect_en;

  if_skid_buffer #(
    .DATA_SIZE(DATA_SIZE)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .load     (skid_load),
    .unload   (skid_unload),
    .clear    (redirect_en),
    .load_pc  (pc_q),
    .load_inst(inst_mem_rd_dat),
    .full     (skid_full),
    .buf_pc   (skid_pc),
    .buf_inst (skid_inst)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      if_id_valid  <= 1'b0;
      if_id_pc     <= '0;
      if_id_inst   <= NOP_INST;
    end else if (redirect_en) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
      pc_q        <= redirect_target;
      unique case (state_q)
        FETCH: begin
          // An outstanding request without ack must still complete before refetching.
          if (!inst_mem_ack) begin
            state_q      <= DRAIN;
            drain_addr_q <= pc_q;
          end
        end
        HOLD:    state_q <= FETCH;
        // Ack in the same cycle ends the drained transaction; otherwise keep draining.
        DRAIN:   if (inst_mem_ack) state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (inst_mem_ack) begin
            pc_q <= pc_q + DATA_SIZE'(4);
            if (id_stall) begin
              state_q <= HOLD;
            end else begin
              if_id_valid <= 1'b1;
              if_id_pc    <= pc_q;
              if_id_inst  <= inst_mem_rd_dat;
            end
          end else if (!id_stall) begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            if_id_valid <= skid_full;
            if_id_pc    <= skid_pc;
            if_id_inst  <= skid_inst;
            state_q     <= FETCH;
          end
        end
        DRAIN:   if (inst_mem_ack) state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage_issue.sv
module tb_if_stage_issue;
  import if_pkg::*;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inst_mem_en, inst_mem_ack = 1'b0;
  logic [63:0] inst_mem_addr;
  logic [31:0] inst_mem_rd_dat = '0;
  logic        id_stall = 1'b0, redirect_en = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_inst;

  // Second instance exercising PC wrap-around; only its ack is private.
  logic        w_en, w_ack = 1'b0, w_valid;
  logic [63:0] w_addr, w_pc;
  logic [31:0] w_inst;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  if_stage_issue #(.DATA_SIZE(64), .RESET_PC(64'h0)) dut (
    .clock(clock), .reset(reset), .inst_mem_en(inst_mem_en), .inst_mem_addr(inst_mem_addr),
    .inst_mem_ack(inst_mem_ack), .inst_mem_rd_dat(inst_mem_rd_dat), .id_stall(id_stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_inst(if_id_inst)
  );

  if_stage_issue #(.DATA_SIZE(64), .RESET_PC(WRAP_PC)) dut_wrap (
    .clock(clock), .reset(reset), .inst_mem_en(w_en), .inst_mem_addr(w_addr),
    .inst_mem_ack(w_ack), .inst_mem_rd_dat(inst_mem_rd_dat), .id_stall(id_stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .if_id_valid(w_valid),
    .if_id_pc(w_pc), .if_id_inst(w_inst)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0003;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench in the first cycle with reset=0, inputs idle.
  task automatic do_reset();
    reset = 1'b1; inst_mem_ack = 1'b0; w_ack = 1'b0; id_stall = 1'b0; redirect_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; inst_mem_ack = 1'b0; id_stall = 1'b0; redirect_en = 1'b0;
    tick();
    #1;
    checks++;
    if ({inst_mem_en, if_id_valid, if_id_pc, if_id_inst} !== {1'b0, 1'b0, 64'h0, NOP_INST}) begin
      errors++;
      $display("FAIL reset_state: got en=%b v=%b pc=%h inst=%h want en=0 v=0 pc=0 inst=%h",
               inst_mem_en, if_id_valid, if_id_pc, if_id_inst, NOP_INST);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({inst_mem_en, inst_mem_addr} !== {1'b1, 64'h0}) begin
      errors++;
      $display("FAIL first_request: got en=%b addr=%h want en=1 addr=0", inst_mem_en,
               inst_mem_addr);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    d = 32'h00A00093;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      inst_mem_ack = 1'b0;
      #1;
      checks++;
      if ({inst_mem_en, inst_mem_addr} !== {1'b1, 64'(4 * i)}) begin
        errors++;
        $display("FAIL basic_req%0d: got en=%b addr=%h want en=1 addr=%h", i, inst_mem_en,
                 inst_mem_addr, 4 * i);
      end
      if (i > 0) begin
        checks++;
        if ({if_id_valid, if_id_pc, if_id_inst} !== {1'b1, 64'(4 * (i - 1)), d}) begin
          errors++;
          $display("FAIL basic_ifid%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", i,
                   if_id_valid, if_id_pc, if_id_inst, 4 * (i - 1), d);
        end
      end
      tick();
      inst_mem_ack = 1'b1; inst_mem_rd_dat = d;
      #1;
      checks++;
      if ({inst_mem_addr, if_id_valid, if_id_inst} !== {64'(4 * i), 1'b0, NOP_INST}) begin
        errors++;
        $display("FAIL basic_bubble%0d: got addr=%h v=%b inst=%h want addr=%h v=0 NOP", i,
                 inst_mem_addr, if_id_valid, if_id_inst, 4 * i);
      end
      tick();
    end
    inst_mem_ack = 1'b0;
    #1;
    checks++;
    if ({if_id_valid, if_id_pc, inst_mem_addr} !== {1'b1, 64'h8, 64'hC}) begin
      errors++;
      $display("FAIL basic_last: got v=%b pc=%h addr=%h want v=1 pc=8 addr=c", if_id_valid,
               if_id_pc, inst_mem_addr);
    end
  endtask

  task automatic test_stall();
    logic [31:0] d0, d1;
    d0 = 32'h00A00093; d1 = 32'h00100113;
    do_reset();
    inst_mem_ack = 1'b1; inst_mem_rd_dat = d0;
    tick();
    id_stall = 1'b1; inst_mem_ack = 1'b1; inst_mem_rd_dat = d1;
    #1;
    checks++;
    if ({if_id_valid, if_id_pc, inst_mem_addr} !== {1'b1, 64'h0, 64'h4}) begin
      errors++;
      $display("FAIL stall_pre: got v=%b pc=%h addr=%h want v=1 pc=0 addr=4", if_id_valid,
               if_id_pc, inst_mem_addr);
    end
    tick();
    inst_mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) id_stall = 1'b0;
      #1;
      checks++;
      if ({inst_mem_en, if_id_valid, if_id_pc, if_id_inst} !== {1'b0, 1'b1, 64'h0, d0}) begin
        errors++;
        $display("FAIL stall_hold%0d: got en=%b v=%b pc=%h inst=%h want en=0 v=1 pc=0 inst=%h",
                 c, inst_mem_en, if_id_valid, if_id_pc, if_id_inst, d0);
      end
      tick();
    end
    #1;
    checks++;
    if ({if_id_valid, if_id_pc, if_id_inst, inst_mem_en, inst_mem_addr} !==
        {1'b1, 64'h4, d1, 1'b1, 64'h8}) begin
      errors++;
      $display("FAIL stall_release: got v=%b pc=%h inst=%h en=%b addr=%h want 1 4 %h 1 8",
               if_id_valid, if_id_pc, if_id_inst, inst_mem_en, inst_mem_addr, d1);
    end
    tick();
    #1;
    checks++;
    if ({inst_mem_addr, if_id_valid} !== {64'h8, 1'b0}) begin
      errors++;
      $display("FAIL stall_norefetch: got addr=%h v=%b want addr=8 v=0", inst_mem_addr,
               if_id_valid);
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    inst_mem_ack = 1'b1; inst_mem_rd_dat = mem_word(64'h0);
    tick();
    inst_mem_rd_dat = mem_word(64'h4);
    tick();
    inst_mem_ack = 1'b0; redirect_en = 1'b1; redirect_pc = 64'h100;
    tick();
    redirect_en = 1'b0;
    #1;
    checks++;
    if ({if_id_valid, if_id_inst, inst_mem_en, inst_mem_addr} !==
        {1'b0, NOP_INST, 1'b1, 64'h8}) begin
      errors++;
      $display("FAIL drain_flush: got v=%b inst=%h en=%b addr=%h want v=0 NOP en=1 addr=8",
               if_id_valid, if_id_inst, inst_mem_en, inst_mem_addr);
    end
    tick();
    #1;
    checks++;
    if (inst_mem_addr !== 64'h8) begin
      errors++;
      $display("FAIL drain_addr_hold: got %h want 8", inst_mem_addr);
    end
    inst_mem_ack = 1'b1; inst_mem_rd_dat = 32'hDEADBEEF;
    tick();
    inst_mem_ack = 1'b0;
    #1;
    checks++;
    if ({if_id_valid, inst_mem_en, inst_mem_addr} !== {1'b0, 1'b1, 64'h100}) begin
      errors++;
      $display("FAIL drain_target: got v=%b en=%b addr=%h want v=0 en=1 addr=100",
               if_id_valid, inst_mem_en, inst_mem_addr);
    end
    inst_mem_ack = 1'b1; inst_mem_rd_dat = 32'h12345678;
    tick();
    inst_mem_ack = 1'b0;
    #1;
    checks++;
    if ({if_id_valid, if_id_pc, if_id_inst} !== {1'b1, 64'h100, 32'h12345678}) begin
      errors++;
      $display("FAIL drain_newpath: got v=%b pc=%h inst=%h want v=1 pc=100 inst=12345678",
               if_id_valid, if_id_pc, if_id_inst);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    inst_mem_ack = 1'b1; inst_mem_rd_dat = mem_word(64'h0);
    tick();
    inst_mem_ack = 1'b0; id_stall = 1'b1; redirect_en = 1'b1; redirect_pc = 64'h203;
    tick();
    id_stall = 1'b0; redirect_en = 1'b0;
    #1;
    checks++;
    if ({if_id_valid, inst_mem_addr} !== {1'b0, 64'h4}) begin
      errors++;
      $display("FAIL rs_flush: got v=%b addr=%h want v=0 addr=4", if_id_valid, inst_mem_addr);
    end
    inst_mem_ack = 1'b1;
    tick();
    inst_mem_ack = 1'b0;
    #1;
    checks++;
    if ({inst_mem_en, inst_mem_addr} !== {1'b1, 64'h200}) begin
      errors++;
      $display("FAIL rs_align: got en=%b addr=%h want en=1 addr=200", inst_mem_en,
               inst_mem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    checks++;
    if ({w_en, w_addr} !== {1'b1, WRAP_PC}) begin
      errors++;
      $display("FAIL wrap_first: got en=%b addr=%h want en=1 addr=%h", w_en, w_addr, WRAP_PC);
    end
    w_ack = 1'b1; inst_mem_rd_dat = 32'h00A00093;
    tick();
    w_ack = 1'b0;
    #1;
    checks++;
    if ({w_addr, w_valid, w_pc, w_inst} !== {64'h0, 1'b1, WRAP_PC, 32'h00A00093}) begin
      errors++;
      $display("FAIL wrap_next: got addr=%h v=%b pc=%h inst=%h want addr=0 v=1 pc=%h",
               w_addr, w_valid, w_pc, w_inst, WRAP_PC);
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    redirect_en = 1'b1; redirect_pc = 64'h40;
    tick();
    redirect_en = 1'b0; reset = 1'b1; inst_mem_ack = 1'b1;
    #1;
    checks++;
    if (inst_mem_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_drain_en: got en=%b want 0", inst_mem_en);
    end
    tick();
    inst_mem_ack = 1'b0;
    #1;
    checks++;
    if ({inst_mem_en, if_id_valid} !== {1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_drain_hold: got en=%b v=%b want 0 0", inst_mem_en, if_id_valid);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({inst_mem_en, inst_mem_addr} !== {1'b1, 64'h0}) begin
      errors++;
      $display("FAIL rst_drain_restart: got en=%b addr=%h want en=1 addr=0", inst_mem_en,
               inst_mem_addr);
    end
  endtask

  // Program-order reference: every instruction ID accepts must be the next sequential
  // PC after reset or the latest redirect, carrying the memory word for that PC.
  task automatic test_random();
    logic [63:0] exp_pc, rp, prev_addr;
    logic        prev_pend, busy;
    int          wait_cnt, accepted;
    if_id_t      obs;
    do_reset();
    exp_pc = 64'h0; prev_pend = 1'b0; busy = 1'b0; wait_cnt = 0; accepted = 0;
    prev_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      id_stall    = ($urandom_range(0, 99) < 30);
      redirect_en = ($urandom_range(0, 99) < 4);
      rp          = 64'($urandom_range(0, 4095));
      redirect_pc = rp;
      inst_mem_ack = 1'b0;
      if (inst_mem_en) begin
        if (!busy) begin
          busy = 1'b1;
          wait_cnt = $urandom_range(0, 3);
        end
        if (wait_cnt == 0) begin
          inst_mem_ack = 1'b1;
          inst_mem_rd_dat = mem_word(inst_mem_addr);
          busy = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      #1;
      obs = '{pc: if_id_pc, inst: if_id_inst, valid: if_id_valid};
      if (prev_pend) begin
        checks++;
        if ({inst_mem_en, inst_mem_addr} !== {1'b1, prev_addr}) begin
          errors++;
          $display("FAIL rnd_addr_hold c%0d: got en=%b addr=%h want en=1 addr=%h", c,
                   inst_mem_en, inst_mem_addr, prev_addr);
        end
      end
      if (!obs.valid) begin
        checks++;
        if (obs.inst !== NOP_INST) begin
          errors++;
          $display("FAIL rnd_nop c%0d: got inst=%h want %h", c, obs.inst, NOP_INST);
        end
      end
      if (redirect_en) begin
        exp_pc = rp & ~64'h3;
      end else if (obs.valid && !id_stall) begin
        checks++;
        if ({obs.pc, obs.inst} !== {exp_pc, mem_word(exp_pc)}) begin
          errors++;
          $display("FAIL rnd_stream c%0d: got pc=%h inst=%h want pc=%h inst=%h", c, obs.pc,
                   obs.inst, exp_pc, mem_word(exp_pc));
          exp_pc = obs.pc;
        end
        exp_pc = exp_pc + 64'h4;
        accepted++;
      end
      prev_pend = inst_mem_en && !inst_mem_ack;
      prev_addr = inst_mem_addr;
      tick();
    end
    id_stall = 1'b0; redirect_en = 1'b0; inst_mem_ack = 1'b0;
    checks++;
    if (accepted < 100) begin
      errors++;
      $display("FAIL rnd_progress: got %0d accepted want at least 100", accepted);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_drain();
    test_redirect_stall();
    test_wrap();
    test_reset_in_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
